// File: rtl/l2_arbiter.sv
// l2_arbiter
//   Shares one L2 request interface between the L1 instruction cache (port I)
//   and the L1 data cache (port D). One line-sized transaction is in flight at
//   a time; contention is resolved round-robin. Every output is a flop.
//
// Handshake: a requester raises read and/or write (level) with addr/wdata and
//   holds them until it sees its one-cycle ready pulse. The arbiter raises
//   exactly one of l2_read/l2_write and holds it, with l2_addr/l2_wdata, until
//   L2 returns a one-cycle l2_ready; l2_rdata is taken in that same cycle.
//
// Ports:
//   clk, reset             clock (rising edge), asynchronous active-low reset
//   i_read/i_write/i_addr/i_wdata -> i_ready, i_rdata   instruction port
//   d_read/d_write/d_addr/d_wdata -> d_ready, d_rdata   data port
//   l2_read/l2_write/l2_addr/l2_wdata, l2_rdata/l2_ready L2 side
//   i_cnt, d_cnt           saturating grant counters per port
//   dbg_state              current FSM state (IDLE=0, BUSY=1, DONE=2)
module l2_arbiter #(
    parameter int ADDR_W = 28,
    parameter int LINE_W = 128,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [LINE_W-1:0] i_wdata,
    output logic              i_ready,
    output logic [LINE_W-1:0] i_rdata,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [LINE_W-1:0] d_rdata,
    output logic              l2_read,
    output logic              l2_write,
    output logic [ADDR_W-1:0] l2_addr,
    output logic [LINE_W-1:0] l2_wdata,
    input  logic [LINE_W-1:0] l2_rdata,
    input  logic              l2_ready,
    output logic [CNT_W-1:0]  i_cnt,
    output logic [CNT_W-1:0]  d_cnt,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t              state_q, state_d;
    logic                last_d_q, last_d_d;   // 1: most recent grant went to D
    logic                gnt_d_q, gnt_d_d;     // 1: transaction in flight belongs to D
    logic                l2_read_q, l2_read_d;
    logic                l2_write_q, l2_write_d;
    logic [ADDR_W-1:0]   l2_addr_q, l2_addr_d;
    logic [LINE_W-1:0]   l2_wdata_q, l2_wdata_d;
    logic                i_ready_q, i_ready_d;
    logic                d_ready_q, d_ready_d;
    logic [LINE_W-1:0]   i_rdata_q, i_rdata_d;
    logic [LINE_W-1:0]   d_rdata_q, d_rdata_d;
    logic [CNT_W-1:0]    i_cnt_q, i_cnt_d;
    logic [CNT_W-1:0]    d_cnt_q, d_cnt_d;

    logic req_i, req_d, pick_d;

    always_comb begin
        req_i  = i_read | i_write;
        req_d  = d_read | d_write;
        // D wins when it is the only requester, or on a tie when I went last.
        pick_d = req_d & (~req_i | ~last_d_q);

        state_d    = state_q;
        last_d_d   = last_d_q;
        gnt_d_d    = gnt_d_q;
        l2_read_d  = l2_read_q;
        l2_write_d = l2_write_q;
        l2_addr_d  = l2_addr_q;
        l2_wdata_d = l2_wdata_q;
        i_ready_d  = 1'b0;
        d_ready_d  = 1'b0;
        i_rdata_d  = i_rdata_q;
        d_rdata_d  = d_rdata_q;
        i_cnt_d    = i_cnt_q;
        d_cnt_d    = d_cnt_q;

        case (state_q)
            IDLE: begin
                if (req_i || req_d) begin
                    gnt_d_d  = pick_d;
                    last_d_d = pick_d;
                    state_d  = BUSY;
                    // read+write together on one port is treated as a write
                    if (pick_d) begin
                        l2_write_d = d_write;
                        l2_read_d  = ~d_write;
                        l2_addr_d  = d_addr;
                        l2_wdata_d = d_wdata;
                        d_cnt_d    = (d_cnt_q == CNT_MAX) ? d_cnt_q : d_cnt_q + CNT_W'(1);
                    end else begin
                        l2_write_d = i_write;
                        l2_read_d  = ~i_write;
                        l2_addr_d  = i_addr;
                        l2_wdata_d = i_wdata;
                        i_cnt_d    = (i_cnt_q == CNT_MAX) ? i_cnt_q : i_cnt_q + CNT_W'(1);
                    end
                end
            end
            BUSY: begin
                // Requester inputs are deliberately ignored until L2 answers.
                if (l2_ready) begin
                    l2_read_d  = 1'b0;
                    l2_write_d = 1'b0;
                    l2_addr_d  = '0;
                    l2_wdata_d = '0;
                    state_d    = DONE;
                    if (gnt_d_q) begin
                        d_ready_d = 1'b1;
                        if (l2_read_q) d_rdata_d = l2_rdata;
                    end else begin
                        i_ready_d = 1'b1;
                        if (l2_read_q) i_rdata_d = l2_rdata;
                    end
                end
            end
            DONE: begin
                // Dead cycle: lets the requester drop its level request.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            last_d_q   <= 1'b1;
            gnt_d_q    <= 1'b0;
            l2_read_q  <= 1'b0;
            l2_write_q <= 1'b0;
            l2_addr_q  <= '0;
            l2_wdata_q <= '0;
            i_ready_q  <= 1'b0;
            d_ready_q  <= 1'b0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
            i_cnt_q    <= '0;
            d_cnt_q    <= '0;
        end else begin
            state_q    <= state_d;
            last_d_q   <= last_d_d;
            gnt_d_q    <= gnt_d_d;
            l2_read_q  <= l2_read_d;
            l2_write_q <= l2_write_d;
            l2_addr_q  <= l2_addr_d;
            l2_wdata_q <= l2_wdata_d;
            i_ready_q  <= i_ready_d;
            d_ready_q  <= d_ready_d;
            i_rdata_q  <= i_rdata_d;
            d_rdata_q  <= d_rdata_d;
            i_cnt_q    <= i_cnt_d;
            d_cnt_q    <= d_cnt_d;
        end
    end

    assign l2_read   = l2_read_q;
    assign l2_write  = l2_write_q;
    assign l2_addr   = l2_addr_q;
    assign l2_wdata  = l2_wdata_q;
    assign i_ready   = i_ready_q;
    assign d_ready   = d_ready_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign i_cnt     = i_cnt_q;
    assign d_cnt     = d_cnt_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_l2_arbiter.sv
// Bench for l2_arbiter. Inputs are driven and outputs sampled on the falling
// clock edge. Expected L2 requests (port, op, addr, wdata) are queued when
// the stimulus is applied and popped when the DUT raises l2_read/l2_write.
// The grant counter width is narrowed so saturation is reachable quickly.
module tb_l2_arbiter;

    localparam int ADDR_W = 28;
    localparam int LINE_W = 128;
    localparam int CNT_W  = 8;
    localparam int EXP_W  = 2 + ADDR_W + LINE_W;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic              clk = 1'b0;
    logic              reset;
    logic              i_read, i_write, d_read, d_write;
    logic [ADDR_W-1:0] i_addr, d_addr;
    logic [LINE_W-1:0] i_wdata, d_wdata;
    logic              i_ready, d_ready;
    logic [LINE_W-1:0] i_rdata, d_rdata;
    logic              l2_read, l2_write, l2_ready;
    logic [ADDR_W-1:0] l2_addr;
    logic [LINE_W-1:0] l2_wdata, l2_rdata;
    logic [CNT_W-1:0]  i_cnt, d_cnt;
    logic [1:0]        dbg_state;

    int err_cnt = 0;
    int chk_cnt = 0;

    logic [EXP_W-1:0]  exp_q[$];
    logic [CNT_W-1:0]  i_cnt_m, d_cnt_m;
    logic [LINE_W-1:0] i_rdata_m, d_rdata_m;

    l2_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_ready(i_ready), .i_rdata(i_rdata),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .l2_read(l2_read), .l2_write(l2_write), .l2_addr(l2_addr), .l2_wdata(l2_wdata),
        .l2_rdata(l2_rdata), .l2_ready(l2_ready),
        .i_cnt(i_cnt), .d_cnt(d_cnt), .dbg_state(dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [LINE_W-1:0] got,
                            input logic [LINE_W-1:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input bit port_d, input bit wr, input logic [ADDR_W-1:0] a,
                            input logic [LINE_W-1:0] wd);
        exp_q.push_back({port_d, wr, a, wd});
    endtask

    task automatic model_reset();
        exp_q.delete();
        i_cnt_m   = '0;
        d_cnt_m   = '0;
        i_rdata_m = '0;
        d_rdata_m = '0;
    endtask

    function automatic logic [LINE_W-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One transaction: find the L2 request, compare it with the queue head,
    // answer after 'lat' BUSY cycles and check the completion on both ports.
    task automatic do_txn(input int lat, input logic [LINE_W-1:0] rdata,
                          input bit drop, input bit mess);
        logic [EXP_W-1:0]  e;
        bit                port_d, wr;
        logic [ADDR_W-1:0] a;
        logic [LINE_W-1:0] wd;
        int                n;
        n = 0;
        while (!(l2_read || l2_write) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!(l2_read || l2_write)) begin
            check_eq("l2_req_timeout", 0, 1);
            return;
        end
        if (exp_q.size() == 0) begin
            check_eq("exp_q_empty", 0, 1);
            return;
        end
        e = exp_q.pop_front();
        {port_d, wr, a, wd} = e;
        check_eq("l2_write", l2_write, wr);
        check_eq("l2_read", l2_read, !wr);
        check_eq("l2_addr", l2_addr, a);
        check_eq("l2_wdata", l2_wdata, wd);
        if (port_d) d_cnt_m = (d_cnt_m == CNT_MAX) ? d_cnt_m : d_cnt_m + 1'b1;
        else        i_cnt_m = (i_cnt_m == CNT_MAX) ? i_cnt_m : i_cnt_m + 1'b1;
        check_eq("i_cnt", i_cnt, i_cnt_m);
        check_eq("d_cnt", d_cnt, d_cnt_m);
        if (mess && !port_d) begin
            i_read  = 1'b0;
            i_write = 1'b0;
            i_addr  = i_addr ^ 28'h5a5;
        end
        for (int c = 0; c < lat; c++) begin
            @(negedge clk);
            check_eq("busy_addr_hold", l2_addr, a);
            check_eq("busy_op_hold", {l2_read, l2_write}, {!wr, wr});
            check_eq("busy_no_ready", {i_ready, d_ready}, 2'b00);
        end
        l2_ready = 1'b1;
        l2_rdata = rdata;
        @(negedge clk);
        l2_ready = 1'b0;
        l2_rdata = rand_line();
        if (!wr) begin
            if (port_d) d_rdata_m = rdata;
            else        i_rdata_m = rdata;
        end
        check_eq("i_ready_pulse", i_ready, !port_d);
        check_eq("d_ready_pulse", d_ready, port_d);
        check_eq("i_rdata", i_rdata, i_rdata_m);
        check_eq("d_rdata", d_rdata, d_rdata_m);
        check_eq("l2_op_drop", {l2_read, l2_write}, 2'b00);
        if (drop) begin
            if (port_d) begin d_read = 1'b0; d_write = 1'b0; end
            else        begin i_read = 1'b0; i_write = 1'b0; end
        end
        @(negedge clk);
        check_eq("ready_one_cycle", {i_ready, d_ready}, 2'b00);
    endtask

    initial begin
        int n;
        int reps;
        reset = 1'b0;
        i_read = 0; i_write = 0; i_addr = '0; i_wdata = '0;
        d_read = 0; d_write = 0; d_addr = '0; d_wdata = '0;
        l2_ready = 0; l2_rdata = '0;
        model_reset();
        repeat (3) @(negedge clk);

        // reset state
        check_eq("rst_l2_op", {l2_read, l2_write}, 2'b00);
        check_eq("rst_l2_addr", l2_addr, 0);
        check_eq("rst_ready", {i_ready, d_ready}, 2'b00);
        check_eq("rst_rdata", i_rdata | d_rdata, 0);
        check_eq("rst_cnt", {i_cnt, d_cnt}, 0);
        check_eq("rst_state", dbg_state, 0);
        reset = 1'b1;
        @(negedge clk);

        // single I read, request visible on L2 one cycle later
        i_read = 1'b1;
        i_addr = 28'h0000010;
        push_exp(1'b0, 1'b0, 28'h0000010, '0);
        @(negedge clk);
        check_eq("lat_l2_read", l2_read, 1'b1);
        do_txn(5, 128'hDEADBEEF_00000001_00000002_00000003, 1'b1, 1'b0);

        // simultaneous first requests at reset exit: I first, then D write
        reset = 1'b0;
        @(negedge clk);
        model_reset();
        check_eq("rst2_rdata", i_rdata, 0);
        i_read = 1'b1; i_addr = 28'h0000030;
        d_write = 1'b1; d_addr = 28'h0000020; d_wdata = {16{8'hA5}};
        push_exp(1'b0, 1'b0, 28'h0000030, '0);
        push_exp(1'b1, 1'b1, 28'h0000020, {16{8'hA5}});
        reset = 1'b1;
        do_txn(1, rand_line(), 1'b1, 1'b0);
        do_txn(2, rand_line(), 1'b1, 1'b0);

        // continuous contention; D drives read+write together (a write)
        i_read = 1'b1; i_addr = 28'h0000100; i_wdata = rand_line();
        d_read = 1'b1; d_write = 1'b1; d_addr = 28'h0000200; d_wdata = rand_line();
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) push_exp(1'b0, 1'b0, 28'h0000100, i_wdata);
            else            push_exp(1'b1, 1'b1, 28'h0000200, d_wdata);
        end
        for (int k = 0; k < 8; k++) begin
            do_txn($urandom_range(0, 3), rand_line(), k >= 6, 1'b0);
        end
        check_eq("contention_i_cnt", i_cnt, 8'd5);
        check_eq("contention_d_cnt", d_cnt, 8'd5);

        // requester drops and changes address mid-BUSY
        i_read = 1'b1; i_addr = 28'h0000400; i_wdata = '0;
        push_exp(1'b0, 1'b0, 28'h0000400, '0);
        do_txn(3, rand_line(), 1'b1, 1'b1);

        // asynchronous reset in the middle of BUSY
        i_read = 1'b1; i_addr = 28'h0000500;
        n = 0;
        while (!l2_read && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("pre_rst_l2_read", l2_read, 1'b1);
        #2 reset = 1'b0;
        #1;
        check_eq("async_rst_l2_read", l2_read, 1'b0);
        check_eq("async_rst_cnt", {i_cnt, d_cnt}, 0);
        check_eq("async_rst_state", dbg_state, 0);
        model_reset();
        i_read = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_eq("post_rst_no_ready", {i_ready, d_ready}, 2'b00);
            check_eq("post_rst_idle", dbg_state, 0);
        end
        // stray l2_ready while IDLE must be ignored
        l2_ready = 1'b1; l2_rdata = rand_line();
        @(negedge clk);
        l2_ready = 1'b0;
        @(negedge clk);
        check_eq("idle_l2_ready_ignored", {i_ready, d_ready, dbg_state}, 4'b0000);
        check_eq("idle_rdata_kept", i_rdata | d_rdata, 0);
        // next conflict goes to I
        i_read = 1'b1; i_addr = 28'h0000600;
        d_read = 1'b1; d_addr = 28'h0000700; d_wdata = '0;
        push_exp(1'b0, 1'b0, 28'h0000600, i_wdata);
        push_exp(1'b1, 1'b0, 28'h0000700, '0);
        do_txn(0, rand_line(), 1'b1, 1'b0);
        do_txn(1, rand_line(), 1'b0, 1'b0);

        // D counter saturation (d_read still held)
        reps = int'(CNT_MAX) - int'(d_cnt_m) + 1;
        for (int k = 0; k < reps; k++) begin
            push_exp(1'b1, 1'b0, 28'h0000700, '0);
            do_txn(0, rand_line(), k == reps - 1, 1'b0);
        end
        check_eq("d_cnt_saturated", d_cnt, CNT_MAX);
        check_eq("i_cnt_after_sat", i_cnt, 8'd1);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/l2_arbiter.md
Name: l2_arbiter

Overview:
Two-port arbiter that shares the single L2 cache request interface between the L1 instruction cache (port I) and the L1 data cache (port D). It accepts one line-sized read or write at a time from either L1 and forwards it to L2 with registered, stable control. It returns the L2 response to the granted requester and round-robins on contention. It also maintains saturating per-port grant counters for performance accounting.

Parameters:
ADDR_W, 28, line address width (word address without the 2-bit word offset)
LINE_W, 128, cache line / data width
CNT_W, 16, grant counter width

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
i_read  input  1  I-port read request, level, held until i_ready
i_write  input  1  I-port write request, level, held until i_ready
i_addr  input  ADDR_W  I-port line address
i_wdata  input  LINE_W  I-port write line
i_ready  output  1  I-port completion pulse, 1 cycle
i_rdata  output  LINE_W  I-port read line, valid when i_ready=1
d_read  input  1  D-port read request
d_write  input  1  D-port write request
d_addr  input  ADDR_W  D-port line address
d_wdata  input  LINE_W  D-port write line
d_ready  output  1  D-port completion pulse, 1 cycle
d_rdata  output  LINE_W  D-port read line, valid when d_ready=1
l2_read  output  1  read request to L2
l2_write  output  1  write request to L2
l2_addr  output  ADDR_W  address to L2
l2_wdata  output  LINE_W  write line to L2
l2_rdata  input  LINE_W  read line from L2
l2_ready  input  1  L2 completion, 1-cycle pulse
i_cnt  output  CNT_W  count of I-port grants, saturating
d_cnt  output  CNT_W  count of D-port grants, saturating

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs 0; state IDLE; last_grant=D, so I wins the first conflict; counters 0.
  - Reset mid-transaction drops l2_read/l2_write immediately. No ready pulse is generated for the aborted request.
- All outputs are registered; no combinational input-to-output paths.
- States: IDLE, BUSY, DONE.
- IDLE:
  - A port requests when read|write is high.
  - If only one port requests, grant that port. If both request, grant the port != last_grant.
  - On grant, latch addr, wdata and op into the l2_* registers, update last_grant, increment that port's counter (holds at all-ones), and go to BUSY.
  - l2_read or l2_write goes high in the cycle after the request is first seen in IDLE.
  - With no request, stay in IDLE; l2_* stay 0.
- Op decode: if read and write are both high on the same port, the request is treated as a write. Exactly one of l2_read/l2_write is ever high.
- BUSY:
  - l2_read/l2_write/l2_addr/l2_wdata are held constant until l2_ready=1.
  - Requester inputs are ignored, including deassertion or address change; the transaction still completes and the ready pulse still fires.
  - On l2_ready=1 (cycle k), in cycle k+1:
    - l2_read/l2_write are 0.
    - The granted port's ready=1 for exactly one cycle.
    - The granted port's rdata = l2_rdata sampled at k for reads; rdata is unchanged for writes.
    - State is DONE.
- DONE:
  - One dead cycle so the requester can drop its request after seeing ready. No new grant is made in DONE. Go to IDLE.
  - A request still high in the following IDLE cycle is treated as a new request (back-to-back allowed).
- rdata registers hold their value until the next read completion on the same port. The ungranted port's outputs never change.
- Latency:
  - Request seen in IDLE at t -> l2 request at t+1.
  - l2_ready at k -> requester ready at k+1.
  - Minimum turnaround is 4 cycles per transaction with a 1-cycle L2.
- Fairness: under continuous contention, grants strictly alternate I, D, I, D.
- l2_ready while IDLE or DONE is ignored.

Test Plan:
- Reset then single I read: i_read=1, i_addr=0x0000010. -> l2_read=1, l2_addr=0x0000010 next cycle. L2 returns l2_rdata=0xDEADBEEF_00000001_00000002_00000003 with l2_ready after 5 cycles -> i_ready pulses 1 cycle with that i_rdata; i_cnt=1; d_ready stays 0.
- Simultaneous first requests: i_read and d_write (d_addr=0x0000020, d_wdata=0xA5..A5) both high at reset exit. -> I granted first. D is then issued: l2_write=1, l2_addr=0x0000020, l2_wdata=0xA5..A5, d_rdata unchanged. Final i_cnt=1, d_cnt=1.
- Continuous contention, both ports held high for 8 transactions. -> grant order I,D,I,D,I,D,I,D; i_cnt=4, d_cnt=4; l2_read and l2_write never high together.
- Requester drops i_read during BUSY and changes i_addr. -> l2_addr unchanged until l2_ready; i_ready still pulses.
- Asynchronous reset asserted mid-BUSY, between clock edges. -> l2_read=0 immediately. After release, no ready pulse, state IDLE, counters 0, next conflict grants I.
- Counter saturation: preload or run 65535 D grants, then one more. -> d_cnt stays 0xFFFF.
